// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// States, word geometry and byte-lane width used by the FSM and the assembler.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FINISH
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader is the master; the byte source / memory side is the slave.
interface imem_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = 3
);
    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes big-endian into a word; the first byte of a word ends
// up in the most significant lane. Reports the lane index and word completion.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              accept,
    output logic [1:0]        idx,
    output logic [WORD_W-1:0] word,
    output logic              word_complete
);
    // Only the older bytes need storage; the newest byte comes straight from byte_in.
    logic [WORD_W-BYTE_W-1:0] word_reg;
    logic [1:0]               idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi == 0) begin : g_new
                assign word[BYTE_W-1:0] = byte_in;
            end else begin : g_old
                assign word[gi*BYTE_W +: BYTE_W] = word_reg[(gi-1)*BYTE_W +: BYTE_W];
            end
        end
    endgenerate

    assign idx           = idx_reg;
    assign word_complete = accept && (idx_reg == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg  <= '0;
            word_reg <= '0;
        end else if (accept) begin
            idx_reg  <= idx_reg + 2'd1;
            word_reg <= word[WORD_W-BYTE_W-1:0];
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Fills the CPU instruction memory from a byte stream, holding the CPU in
// reset for the duration of the load.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 3
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    imem_loader_if.master   bus,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W:0]     count_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   waddr_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic                cpu_hold_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                err_reg;

    logic                accept;
    logic [1:0]          asm_idx;
    logic [WORD_W-1:0]   asm_word;
    logic                word_complete;
    logic                count_ok;
    logic                last_word;

    assign bus.byte_ready = (state_reg == COLLECT);
    assign accept         = bus.byte_valid && bus.byte_ready;
    assign count_ok       = (word_count != '0) && (word_count <= DEPTH);
    assign last_word      = ({1'b0, addr_reg} + (ADDR_W+1)'(1)) == count_reg;

    assign bus.we    = we_reg;
    assign bus.waddr = waddr_reg;
    assign bus.wdata = wdata_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    word_assembler u_asm (
        .clk           (clk),
        .rst           (rst),
        .byte_in       (bus.byte_in),
        .accept        (accept),
        .idx           (asm_idx),
        .word          (asm_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            count_reg    <= '0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            cpu_hold_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            we_reg   <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A load only begins on a word boundary of the assembler.
                    if (start && asm_idx == 2'd0) begin
                        if (count_ok) begin
                            count_reg    <= word_count;
                            addr_reg     <= '0;
                            cpu_hold_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            state_reg    <= COLLECT;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (word_complete) begin
                        we_reg    <= 1'b1;
                        waddr_reg <= addr_reg;
                        wdata_reg <= asm_word;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        addr_reg  <= addr_reg + 1'b1;
                        state_reg <= COLLECT;
                    end
                end
                FINISH: begin
                    cpu_hold_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
